// File: rtl/prefix_add_pkg.sv
// rtl/prefix_add_pkg.sv - shared types and helpers for the pipelined prefix adder
//
// Purpose: default width, log2 helper, generate/propagate pair type and the
// Kogge-Stone black-cell combine used by every prefix level.
package prefix_add_pkg;

    localparam int WIDTH_DEFAULT = 32;

    function automatic int log2w(input int w);
        int n;
        for (n = 0; (1 << n) < w; n++) begin
        end
        return n;
    endfunction

    localparam int LOG2W = log2w(WIDTH_DEFAULT);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // hi covers the more significant span, lo the adjacent less significant one
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// rtl/prefix_cell.sv - combinational Kogge-Stone black cell
//
// Ports:
//   i_hi  group (g,p) of the upper span
//   i_lo  group (g,p) of the adjacent lower span
//   o_gp  combined group covering both spans
module prefix_cell
    import prefix_add_pkg::*;
(
    input  gp_t i_hi,
    input  gp_t i_lo,
    output gp_t o_gp
);

    assign o_gp = gp_combine(i_hi, i_lo);

endmodule

// File: rtl/prefix_add_pipe.sv
// rtl/prefix_add_pipe.sv - two-stage pipelined Kogge-Stone adder with valid/ready
//
// Purpose: sum = a + b + cin with carry, signed overflow and zero flags. The
// prefix tree is cut after SPLIT_LEVEL levels; stage 2 finishes the tree and
// registers the results, so every output comes straight from a flop.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready, a, b, cin operand handshake and operands
//   out_valid/out_ready          result handshake
//   sum, cout, ovf, zero         registered result and flags
module prefix_add_pipe
    import prefix_add_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SPLIT_LEVEL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LEVELS = log2w(WIDTH);
    localparam int NS2    = LEVELS - SPLIT_LEVEL;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_p;
    logic             r_s1_cin;
    gp_t              r_s1_gp [WIDTH];

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_load;
    logic [WIDTH-1:0] w_gc;
    logic [WIDTH-1:0] w_sum;

    gp_t w_s1 [SPLIT_LEVEL+1][WIDTH];
    gp_t w_s2 [NS2+1][WIDTH];

    // Ready chain: valids never feed forward combinationally, only out_ready
    // ripples back to in_ready.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_load   = in_valid && w_s1_adv;

    // Level 0: cin is folded into bit 0 as a generate from position -1, so the
    // final group generate at bit i is the carry out of bit i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_init
        if (i == 0) begin : g_lsb
            assign w_s1[0][i] = '{g: (a[i] & b[i]) | ((a[i] ^ b[i]) & cin), p: a[i] ^ b[i]};
        end else begin : g_bit
            assign w_s1[0][i] = '{g: a[i] & b[i], p: a[i] ^ b[i]};
        end
    end

    for (genvar l = 0; l < SPLIT_LEVEL; l++) begin : g_s1_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_cell
                prefix_cell u_cell (
                    .i_hi (w_s1[l][i]),
                    .i_lo (w_s1[l][i-(1<<l)]),
                    .o_gp (w_s1[l+1][i])
                );
            end else begin : g_pass
                assign w_s1[l+1][i] = w_s1[l][i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_s2_init
        assign w_s2[0][i] = r_s1_gp[i];
    end

    for (genvar l = 0; l < NS2; l++) begin : g_s2_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << (SPLIT_LEVEL + l))) begin : g_cell
                prefix_cell u_cell (
                    .i_hi (w_s2[l][i]),
                    .i_lo (w_s2[l][i-(1<<(SPLIT_LEVEL+l))]),
                    .o_gp (w_s2[l+1][i])
                );
            end else begin : g_pass
                assign w_s2[l+1][i] = w_s2[l][i];
            end
        end
        end

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign w_gc[i] = w_s2[NS2][i].g;
    end

    assign w_sum = r_s1_p ^ {w_gc[WIDTH-2:0], r_s1_cin};

    // Stage 1 data needs no reset: it is only consumed while r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_s1_p   <= a ^ b;
            r_s1_cin <= cin;
            for (int i = 0; i < WIDTH; i++) begin
                r_s1_gp[i] <= w_s1[SPLIT_LEVEL][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                // Bubbles leave the previous result in place; it is masked by out_valid.
                if (r_s1_valid) begin
                    r_sum  <= w_sum;
                    r_cout <= w_gc[WIDTH-1];
                    r_ovf  <= w_gc[WIDTH-2] ^ w_gc[WIDTH-1];
                    r_zero <= (w_sum == '0);
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_prefix_add_pipe.sv
// tb/tb_prefix_add_pipe.sv - scoreboard bench for the pipelined prefix adder
module tb_prefix_add_pipe;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int   total = 0;
    int   bad = 0;
    res_t sb[$];
    logic hold_pending = 1'b0;
    res_t held;

    prefix_add_pipe #(.WIDTH(W), .SPLIT_LEVEL(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        res_t       r;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples at the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending)
                chk("hold_stable", {out_valid, sum, cout, ovf, zero}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (sb.size() == 0)
                    chk("unexpected_output", 64'd1, 64'd0);
                else
                    chk("result", {sum, cout, ovf, zero}, sb.pop_front());
            end
            if (in_valid && in_ready)
                sb.push_back(model(a, b, cin));
            hold_pending = out_valid && !out_ready;
            held         = {sum, cout, ovf, zero};
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(posedge clk); #1;
        a = x; b = y; cin = c; in_valid = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic rand_ops(output logic [W-1:0] x, output logic [W-1:0] y, output logic c);
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? ~x : $urandom;
        c = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] x, y;
        logic         c;
        logic         took;
        int           acc;

        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Two-cycle latency on a simple add
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        idle();
        @(negedge clk);
        chk("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_out_valid", out_valid, 1);
        wait_drain();

        // Carry ripple across the split and overflow corners
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b0);
        idle();
        wait_drain();

        // Streaming: one result per cycle, in_ready never drops
        for (int i = 0; i < 100; i++) begin
            rand_ops(x, y, c);
            send(x, y, c);
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            if (i >= 2)
                chk("stream_out_valid", out_valid, 1);
        end
        idle();
        wait_drain();

        // Backpressure from an empty pipe: exactly two accepts, then stall
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_ops(x, y, c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) begin
                rand_ops(x, y, c);
                a = x; b = y; cin = c;
            end
        end
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_accepts", acc, 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Random valid and backpressure
        took = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                rand_ops(x, y, c);
                a = x; b = y; cin = c;
                in_valid = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            took = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        rand_ops(x, y, c);
        a = x; b = y; cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        rand_ops(x, y, c);
        a = x; b = y; cin = c;
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        hold_pending = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_flags", {cout, ovf, zero}, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_out_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            rand_ops(x, y, c);
            send(x, y, c);
        end
        idle();
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
